serial_frame_deserializer: RTL and testbench

Serial-in/parallel-out receiver: collects a WIDTH-bit frame from a 1-bit serial stream strobed by a bit-enable, then presents it as a parallel word under a valid/ready handshake. It is the receive end of the load/shift serial path built from the clocked load-select mux cells. It sits between the serial link and the pipeline's parallel register/writeback side.

---
 rtl/serial_pkg.sv | 21 ++
 rtl/serial_frame_deserializer_if.sv | 29 ++
 rtl/serial_bit_counter.sv | 35 +++
 rtl/serial_frame_deserializer.sv | 148 ++++++++++++++
 tb/tb_serial_frame_deserializer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame deserializer.
//   state_t       - receiver FSM states (PARITY only reachable when the
//                   SERIAL_DESER_PARITY_EN build option is defined)
//   DEFAULT_WIDTH - default frame payload width in bits
//   cnt_width()   - bit-counter width able to hold 0..width
package serial_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    HOLD   = 2'd2,
    PARITY = 2'd3
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_frame_deserializer_if.sv
// Bundle between the serial link / parallel consumer and the deserializer.
//   sin, sin_en, frame_start : serial bit, bit strobe, frame-start qualifier
//   pout, pout_valid, pout_ready : parallel word handshake
//   busy, overrun, parity_err    : status
// modport slave  - the deserializer
// modport master - the environment driving the link and consuming words
interface serial_frame_deserializer_if #(
  parameter int WIDTH = serial_pkg::DEFAULT_WIDTH
);
  logic             sin;
  logic             sin_en;
  logic             frame_start;
  logic [WIDTH-1:0] pout;
  logic             pout_valid;
  logic             pout_ready;
  logic             busy;
  logic             overrun;
  logic             parity_err;

  modport slave (
    input  sin, sin_en, frame_start, pout_ready,
    output pout, pout_valid, busy, overrun, parity_err
  );

  modport master (
    output sin, sin_en, frame_start, pout_ready,
    input  pout, pout_valid, busy, overrun, parity_err
  );
endinterface

// File: rtl/serial_bit_counter.sv
// Payload bit counter for the deserializer.
//   clk, rst (sync, active-low) : clock / reset
//   load : start of frame, count <= 1 (bit 0 is captured in the same cycle)
//   inc  : one more payload bit captured; saturates at WIDTH, never wraps
//   last : count == WIDTH-1, i.e. the next captured bit completes the frame
module serial_bit_counter
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic inc,
  output logic last
);
  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(1);
    end else if (inc && (count != CW'(WIDTH))) begin
      count <= count + CW'(1);
    end
  end

  // Flagged one bit early so the FSM can leave SHIFT on the same edge that
  // captures the final bit, keeping pout_valid one cycle behind it.
  assign last = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_frame_deserializer.sv
// Serial-in / parallel-out frame receiver.
// Collects WIDTH bits strobed by sin_en (frame_start marks bit 0) and holds
// the assembled word on pout under a pout_valid/pout_ready handshake.
//   clk  : clock, all state on posedge
//   rst  : synchronous active-low reset
//   bus  : serial_frame_deserializer_if.slave (serial input, parallel output,
//          busy / sticky overrun / parity_err status)
// Parameters: WIDTH (payload bits, >= 2), MSB_FIRST (1: first bit -> pout[WIDTH-1]).
// Build option SERIAL_DESER_PARITY_EN: one extra even-parity bit follows the
// payload; parity_err reports XOR(payload, parity bit). Undefined: parity_err = 0.
//
// state  | meaning
// IDLE   | waiting for frame_start & sin_en
// SHIFT  | collecting payload bits
// PARITY | waiting for the parity bit (parity build only)
// HOLD   | word presented, waiting for pout_ready
module serial_frame_deserializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                         clk,
  input logic                         rst,
  serial_frame_deserializer_if.slave  bus
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [WIDTH-1:0] shifted, start_word;
  logic [WIDTH-1:0] pout_r;
  logic             pout_valid_r, busy_r, overrun_r;
  logic             start, cnt_load, cnt_inc, cnt_last, overrun_set;

  serial_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .inc  (cnt_inc),
    .last (cnt_last)
  );

  assign start = bus.sin_en & bus.frame_start;

  assign shifted    = MSB_FIRST ? {sreg[WIDTH-2:0], bus.sin} : {bus.sin, sreg[WIDTH-1:1]};
  // A new frame clears the rest of the register so aborted partial data
  // never leaks into the next word.
  assign start_word = MSB_FIRST ? {{(WIDTH-1){1'b0}}, bus.sin} : {bus.sin, {(WIDTH-1){1'b0}}};

  always_comb begin
    state_nxt   = state;
    sreg_nxt    = sreg;
    cnt_load    = 1'b0;
    cnt_inc     = 1'b0;
    overrun_set = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          sreg_nxt  = start_word;
          cnt_load  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (start) begin
          sreg_nxt = start_word;
          cnt_load = 1'b1;
        end else if (bus.sin_en) begin
          sreg_nxt = shifted;
          cnt_inc  = 1'b1;
          if (cnt_last) begin
`ifdef SERIAL_DESER_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = HOLD;
`endif
          end
        end
      end
`ifdef SERIAL_DESER_PARITY_EN
      PARITY: begin
        if (start) begin
          sreg_nxt  = start_word;
          cnt_load  = 1'b1;
          state_nxt = SHIFT;
        end else if (bus.sin_en) begin
          state_nxt = HOLD;
        end
      end
`endif
      HOLD: begin
        if (bus.pout_ready) begin
          state_nxt = IDLE;
          // Back-to-back: the transfer and bit 0 of the next frame share a cycle.
          if (start) begin
            sreg_nxt  = start_word;
            cnt_load  = 1'b1;
            state_nxt = SHIFT;
          end
        end else if (start) begin
          overrun_set = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      sreg         <= '0;
      pout_r       <= '0;
      pout_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      state        <= state_nxt;
      sreg         <= sreg_nxt;
      pout_valid_r <= (state_nxt == HOLD);
      busy_r       <= (state_nxt == SHIFT);
      if (overrun_set) overrun_r <= 1'b1;
      // pout is loaded once on entry to HOLD and frozen until the next entry.
      if ((state_nxt == HOLD) && (state != HOLD)) pout_r <= sreg_nxt;
    end
  end

`ifdef SERIAL_DESER_PARITY_EN
  logic parity_r;

  always_ff @(posedge clk) begin
    if (!rst) begin
      parity_r <= 1'b0;
    end else if ((state == PARITY) && (state_nxt == HOLD)) begin
      parity_r <= (^sreg) ^ bus.sin;
    end
  end

  assign bus.parity_err = parity_r;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.pout       = pout_r;
  assign bus.pout_valid = pout_valid_r;
  assign bus.busy       = busy_r;
  assign bus.overrun    = overrun_r;

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Directed bench: two WIDTH=8 instances (MSB_FIRST=1 and 0) driven by the
// same serial stream. Table of frames plus hand-written corner sequences.
module tb_serial_frame_deserializer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sin = 1'b0;
  logic sin_en = 1'b0;
  logic frame_start = 1'b0;
  logic pout_ready = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  serial_frame_deserializer_if #(.WIDTH(8)) if_m ();
  serial_frame_deserializer_if #(.WIDTH(8)) if_l ();

  assign if_m.sin         = sin;
  assign if_m.sin_en      = sin_en;
  assign if_m.frame_start = frame_start;
  assign if_m.pout_ready  = pout_ready;
  assign if_l.sin         = sin;
  assign if_l.sin_en      = sin_en;
  assign if_l.frame_start = frame_start;
  assign if_l.pout_ready  = pout_ready;

  serial_frame_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk (clk), .rst (rst), .bus (if_m)
  );
  serial_frame_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk (clk), .rst (rst), .bus (if_l)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] bits;   // bits[7] is sent first
    bit         gap;    // idle cycle between bits
    logic [7:0] exp_m;
    logic [7:0] exp_l;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send_bit(input logic b, input logic fs);
    @(negedge clk);
    sin = b;
    sin_en = 1'b1;
    frame_start = fs;
    @(posedge clk);
    #1;
    sin_en = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit gap,
                            output bit busy_ok, output bit early_valid);
    busy_ok = 1'b1;
    early_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_bit(b[7-i], (i == 0));
      if (i < 7) begin
        if (!(if_m.busy && if_l.busy)) busy_ok = 1'b0;
        if (if_m.pout_valid || if_l.pout_valid) early_valid = 1'b1;
        if (gap) begin
          idle_cycle();
          if (!(if_m.busy && if_l.busy)) busy_ok = 1'b0;
          if (if_m.pout_valid || if_l.pout_valid) early_valid = 1'b1;
        end
      end
    end
`ifdef SERIAL_DESER_PARITY_EN
    if (if_m.pout_valid || if_l.pout_valid) early_valid = 1'b1;
    send_bit(^b, 1'b0);
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, " pout_m"}, 32'(if_m.pout), 32'h0);
    check({tag, " pout_l"}, 32'(if_l.pout), 32'h0);
    check({tag, " valid"}, 32'(if_m.pout_valid | if_l.pout_valid), 32'h0);
    check({tag, " busy"}, 32'(if_m.busy | if_l.busy), 32'h0);
    check({tag, " overrun"}, 32'(if_m.overrun | if_l.overrun), 32'h0);
    check({tag, " parity_err"}, 32'(if_m.parity_err | if_l.parity_err), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit busy_ok, early;

    vecs[0] = '{bits: 8'hB2, gap: 1'b0, exp_m: 8'hB2, exp_l: 8'h4D};
    vecs[1] = '{bits: 8'hB2, gap: 1'b1, exp_m: 8'hB2, exp_l: 8'h4D};
    vecs[2] = '{bits: 8'hFF, gap: 1'b0, exp_m: 8'hFF, exp_l: 8'hFF};
    vecs[3] = '{bits: 8'h0F, gap: 1'b0, exp_m: 8'h0F, exp_l: 8'hF0};
    vecs[4] = '{bits: 8'h01, gap: 1'b1, exp_m: 8'h01, exp_l: 8'h80};

    // Reset state
    rst = 1'b0;
    repeat (2) idle_cycle();
    check_zero("reset");
    rst = 1'b1;

    // Table frames, consumer always ready
    pout_ready = 1'b1;
    foreach (vecs[k]) begin
      send_frame(vecs[k].bits, vecs[k].gap, busy_ok, early);
      check($sformatf("v%0d busy during frame", k), 32'(busy_ok), 32'h1);
      check($sformatf("v%0d no early valid", k), 32'(early), 32'h0);
      check($sformatf("v%0d valid_m", k), 32'(if_m.pout_valid), 32'h1);
      check($sformatf("v%0d valid_l", k), 32'(if_l.pout_valid), 32'h1);
      check($sformatf("v%0d pout_m", k), 32'(if_m.pout), 32'(vecs[k].exp_m));
      check($sformatf("v%0d pout_l", k), 32'(if_l.pout), 32'(vecs[k].exp_l));
      check($sformatf("v%0d parity_err", k), 32'(if_m.parity_err), 32'h0);
      check($sformatf("v%0d busy in hold", k), 32'(if_m.busy), 32'h0);
      idle_cycle();
      check($sformatf("v%0d valid after xfer", k), 32'(if_m.pout_valid | if_l.pout_valid), 32'h0);
      check($sformatf("v%0d busy after xfer", k), 32'(if_m.busy | if_l.busy), 32'h0);
    end

    // Overrun: new frame_start while HOLD not drained
    pout_ready = 1'b0;
    send_frame(8'hB2, 1'b0, busy_ok, early);
    check("ovr held valid", 32'(if_m.pout_valid), 32'h1);
    check("ovr overrun before", 32'(if_m.overrun), 32'h0);
    send_bit(1'b1, 1'b1);
    check("ovr overrun_m", 32'(if_m.overrun), 32'h1);
    check("ovr overrun_l", 32'(if_l.overrun), 32'h1);
    check("ovr busy", 32'(if_m.busy), 32'h0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    check("ovr pout_m frozen", 32'(if_m.pout), 32'hB2);
    check("ovr pout_l frozen", 32'(if_l.pout), 32'h4D);
    check("ovr still valid", 32'(if_m.pout_valid), 32'h1);
    pout_ready = 1'b1;
    idle_cycle();
    check("ovr valid drained", 32'(if_m.pout_valid), 32'h0);
    check("ovr sticky", 32'(if_m.overrun), 32'h1);
    send_bit(1'b1, 1'b0);
    check("ovr idle ignores non-start", 32'(if_m.busy), 32'h0);

    // Back-to-back: handshake and next frame_start in the same cycle
    pout_ready = 1'b0;
    send_frame(8'hB2, 1'b0, busy_ok, early);
    check("b2b first valid", 32'(if_m.pout_valid), 32'h1);
    check("b2b first pout", 32'(if_m.pout), 32'hB2);
    pout_ready = 1'b1;
    send_frame(8'hFF, 1'b0, busy_ok, early);
    check("b2b second busy", 32'(busy_ok), 32'h1);
    check("b2b valid dropped on xfer", 32'(early), 32'h0);
    check("b2b second valid", 32'(if_m.pout_valid), 32'h1);
    check("b2b second pout_m", 32'(if_m.pout), 32'hFF);
    check("b2b second pout_l", 32'(if_l.pout), 32'hFF);
    idle_cycle();
    check("b2b valid after", 32'(if_m.pout_valid), 32'h0);

    // Abort: frame_start after 5 bits restarts the frame
    for (int i = 0; i < 5; i++) send_bit(1'b1, (i == 0));
    check("abort partial busy", 32'(if_m.busy), 32'h1);
    check("abort partial valid", 32'(if_m.pout_valid), 32'h0);
    send_frame(8'h0F, 1'b0, busy_ok, early);
    check("abort no early valid", 32'(early), 32'h0);
    check("abort valid", 32'(if_m.pout_valid), 32'h1);
    check("abort pout_m", 32'(if_m.pout), 32'h0F);
    check("abort pout_l", 32'(if_l.pout), 32'hF0);
    idle_cycle();
    check("abort single pulse", 32'(if_m.pout_valid), 32'h0);

    // Reset mid-frame, then a clean frame
    for (int i = 0; i < 4; i++) send_bit(1'b1, (i == 0));
    rst = 1'b0;
    idle_cycle();
    check_zero("rst mid");
    rst = 1'b1;
    send_frame(8'hB2, 1'b0, busy_ok, early);
    check("post-rst pout_m", 32'(if_m.pout), 32'hB2);
    check("post-rst pout_l", 32'(if_l.pout), 32'h4D);
    check("post-rst valid", 32'(if_m.pout_valid), 32'h1);
    idle_cycle();

    // Reset while holding drops valid without transfer
    pout_ready = 1'b0;
    send_frame(8'hFF, 1'b0, busy_ok, early);
    check("rst hold valid before", 32'(if_m.pout_valid), 32'h1);
    rst = 1'b0;
    idle_cycle();
    check("rst hold valid", 32'(if_m.pout_valid), 32'h0);
    check("rst hold pout", 32'(if_m.pout), 32'h0);
    rst = 1'b1;
    pout_ready = 1'b1;

`ifdef SERIAL_DESER_PARITY_EN
    // Wrong parity bit: B2 has four ones, so a parity bit of 1 is an error
    for (int i = 0; i < 8; i++) begin
      logic [7:0] w;
      w = 8'hB2;
      send_bit(w[7-i], (i == 0));
    end
    check("par wait valid", 32'(if_m.pout_valid), 32'h0);
    send_bit(1'b1, 1'b0);
    check("par bad valid", 32'(if_m.pout_valid), 32'h1);
    check("par bad err", 32'(if_m.parity_err), 32'h1);
    check("par bad pout", 32'(if_m.pout), 32'hB2);
    idle_cycle();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
